bfm_apb_gpio_slave: RTL and testbench

APB3 GPIO register slave that sits directly downstream of the AHB-to-APB bridge BFM and consumes one of its 16 PSEL lines. It provides output data and direction registers, a synchronised input register, and rising-edge interrupt capture. Programmable wait states and PSLVERR generation let the bench exercise the bridge's PREADY and error paths.

---
 rtl/bfm_apb_gpio_slave.sv | 173 +++++++++++++++++
 tb/tb_bfm_apb_gpio_slave.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfm_apb_gpio_slave.sv
// APB3 GPIO slave: DOUT/DIR/IEN registers, synchronised DIN, rising-edge ISTAT (W1C) and level INT.
// Latency: WAIT_STATES+2 cycles per transfer; pin edge reaches DIN after two flops, ISTAT/INT one edge later.
// Backpressure: PREADY held low for WAIT_STATES access cycles; an errored transfer changes no register.
module bfm_apb_gpio_slave #(
    parameter int WIDTH       = 8,
    parameter int WAIT_STATES = 1,
    parameter int TPD         = 1
) (
    input  logic             HCLK,
    input  logic             HRESETN,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [7:0]       PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic [WIDTH-1:0] GPIO_IN,
    output logic [WIDTH-1:0] GPIO_OUT,
    output logic [WIDTH-1:0] GPIO_OE,
    output logic             INT
);

    // Outputs switch with zero delay in this synthesizable model; TPD is range-checked only.
    if (WIDTH < 1 || WIDTH > 32 || WAIT_STATES < 0 || WAIT_STATES > 15 || TPD < 0) begin : g_param_check
        $error("bfm_apb_gpio_slave: parameter out of range");
    end

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       wcnt, wcnt_nxt;

    logic [WIDTH-1:0] dout, dir, ien, istat;
    logic [WIDTH-1:0] sync1, sync2, prev;
    logic [1:0]       fill;

    logic             setup, access, pready, complete;
    logic             sel_dout, sel_dir, sel_din, sel_ien, sel_istat;
    logic             addr_err, wr;
    logic [WIDTH-1:0] wdat, rdata, rise, clr;
    logic [31:0]      prdata_c;
    logic             unused_pwdata;

    assign unused_pwdata = &{1'b0, PWDATA};

    assign setup    = PSEL & ~PENABLE;
    assign access   = PSEL & PENABLE;
    assign pready   = (state == ST_WAIT) && (wcnt == 4'd0);
    assign complete = pready & access;

    // Full-byte decode: misaligned addresses match nothing and therefore error.
    assign sel_dout  = (PADDR == 8'h00);
    assign sel_dir   = (PADDR == 8'h04);
    assign sel_din   = (PADDR == 8'h08);
    assign sel_ien   = (PADDR == 8'h0C);
    assign sel_istat = (PADDR == 8'h10);
    assign addr_err  = ~(sel_dout | sel_dir | sel_din | sel_ien | sel_istat) | (PWRITE & sel_din);

    assign wr   = complete & PWRITE & ~addr_err;
    assign wdat = PWDATA[WIDTH-1:0];
    assign clr  = (wr && sel_istat) ? wdat : '0;

    // Rising edge only once prev holds a genuine earlier sample.
    assign rise = sync2 & ~prev;

    // Transfer state and wait-state counter register.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state <= ST_IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Next state: setup loads the counter, access cycles count it down, PSEL loss aborts.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (setup) begin
                    state_nxt = ST_WAIT;
                    wcnt_nxt  = WS_LOAD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_nxt = ST_IDLE;
                end else if (PENABLE) begin
                    if (wcnt == 4'd0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        wcnt_nxt = wcnt - 4'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read mux over the register map.
    always_comb begin
        rdata = '0;
        if (sel_dout)  rdata = dout;
        if (sel_dir)   rdata = dir;
        if (sel_din)   rdata = sync2;
        if (sel_ien)   rdata = ien;
        if (sel_istat) rdata = istat;
    end

    // PRDATA is live only during an error-free completion cycle.
    always_comb begin
        prdata_c = '0;
        if (complete && !addr_err) prdata_c[WIDTH-1:0] = rdata;
    end

    // Control registers commit on the edge that ends a clean write completion.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            dout <= '0;
            dir  <= '0;
            ien  <= '0;
        end else if (wr) begin
            if (sel_dout) dout <= wdat;
            if (sel_dir)  dir  <= wdat;
            if (sel_ien)  ien  <= wdat;
        end
    end

    // Interrupt status: W1C clear, with a coincident edge taking priority.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            istat <= '0;
        end else begin
            istat <= (istat & ~clr) | rise;
        end
    end

    // Pin synchroniser; prev fills alongside sync2 for the first two edges so a pin held high through reset makes no edge.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            fill  <= 2'b00;
        end else begin
            sync1 <= GPIO_IN;
            sync2 <= sync1;
            prev  <= fill[1] ? sync2 : sync1;
            fill  <= {fill[0], 1'b1};
        end
    end

    assign PRDATA   = prdata_c;
    assign PREADY   = pready;
    assign PSLVERR  = pready & addr_err;
    assign GPIO_OUT = dout;
    assign GPIO_OE  = dir;
    assign INT      = |(istat & ien);

endmodule

// File: tb/tb_bfm_apb_gpio_slave.sv
// Bench for bfm_apb_gpio_slave: three instances (WAIT_STATES 1, 0, 3) share one APB bus and pin bus.
// Latency: a behavioural model predicts every output each cycle; directed tests pin literal values.
// Backpressure: APB transfers wait on PREADY with a bounded cycle budget.
module tb_bfm_apb_gpio_slave;

    localparam int W = 8;

    logic          HCLK = 1'b0;
    logic          HRESETN;
    logic [2:0]    psel;
    logic          PENABLE, PWRITE;
    logic [7:0]    PADDR;
    logic [31:0]   PWDATA;
    logic [W-1:0]  gpio_in;
    logic [31:0]   prdata  [3];
    logic          pready  [3];
    logic          pslverr [3];
    logic          int_o   [3];
    logic [W-1:0]  gout    [3];
    logic [W-1:0]  goe     [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 HCLK = ~HCLK;

    bfm_apb_gpio_slave #(.WIDTH(W), .WAIT_STATES(1), .TPD(1)) u_ws1 (
        .HCLK(HCLK), .HRESETN(HRESETN), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
        .GPIO_IN(gpio_in), .GPIO_OUT(gout[0]), .GPIO_OE(goe[0]), .INT(int_o[0]));

    bfm_apb_gpio_slave #(.WIDTH(W), .WAIT_STATES(0), .TPD(1)) u_ws0 (
        .HCLK(HCLK), .HRESETN(HRESETN), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
        .GPIO_IN(gpio_in), .GPIO_OUT(gout[1]), .GPIO_OE(goe[1]), .INT(int_o[1]));

    bfm_apb_gpio_slave #(.WIDTH(W), .WAIT_STATES(3), .TPD(1)) u_ws3 (
        .HCLK(HCLK), .HRESETN(HRESETN), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]),
        .GPIO_IN(gpio_in), .GPIO_OUT(gout[2]), .GPIO_OE(goe[2]), .INT(int_o[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_dout [3], m_dir [3], m_ien [3], m_istat [3];
    bit           m_inx  [3];     // transfer accepted, not yet finished
    int           m_acc  [3];     // access cycles already spent waiting
    logic [W-1:0] pins [$];       // pins[0] = most recent sample
    int           nsamp;          // samples taken since reset

    function automatic int ws_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic bit bad_access(input logic [7:0] a, input logic w);
        bit known;
        known = (a == 8'h00) || (a == 8'h04) || (a == 8'h08) || (a == 8'h0C) || (a == 8'h10);
        return !known || (w && a == 8'h08);
    endfunction

    function automatic logic [31:0] m_reg(input int i, input logic [7:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            8'h00: v = 32'(m_dout[i]);
            8'h04: v = 32'(m_dir[i]);
            8'h08: v = 32'(pins[1]);
            8'h0C: v = 32'(m_ien[i]);
            8'h10: v = 32'(m_istat[i]);
            default: v = '0;
        endcase
        return v;
    endfunction

    initial begin
        logic [W-1:0] rise, clr;
        forever begin
            @(posedge HCLK or negedge HRESETN);
            if (!HRESETN) begin
                for (int i = 0; i < 3; i++) begin
                    m_dout[i] = '0; m_dir[i] = '0; m_ien[i] = '0; m_istat[i] = '0;
                    m_inx[i] = 1'b0; m_acc[i] = 0;
                end
                pins.delete();
                repeat (3) pins.push_back('0);
                nsamp = 0;
            end else begin
                rise = (nsamp >= 3) ? (pins[1] & ~pins[2]) : '0;
                for (int i = 0; i < 3; i++) begin
                    clr = '0;
                    if (m_inx[i]) begin
                        if (!psel[i]) begin
                            m_inx[i] = 1'b0;
                        end else if (PENABLE) begin
                            if (m_acc[i] == ws_of(i)) begin
                                m_inx[i] = 1'b0;
                                if (PWRITE && !bad_access(PADDR, PWRITE)) begin
                                    case (PADDR)
                                        8'h00: m_dout[i] = PWDATA[W-1:0];
                                        8'h04: m_dir[i]  = PWDATA[W-1:0];
                                        8'h0C: m_ien[i]  = PWDATA[W-1:0];
                                        8'h10: clr       = PWDATA[W-1:0];
                                        default: ;
                                    endcase
                                end
                            end else begin
                                m_acc[i] = m_acc[i] + 1;
                            end
                        end
                    end else if (psel[i] && !PENABLE) begin
                        m_inx[i] = 1'b1;
                        m_acc[i] = 0;
                    end
                    m_istat[i] = (m_istat[i] & ~clr) | rise;
                end
                pins.push_front(gpio_in);
                void'(pins.pop_back());
                nsamp++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, mid-cycle.
    initial begin
        logic        e_rdy, e_err, e_done;
        logic [31:0] e_rd;
        forever begin
            @(negedge HCLK);
            for (int i = 0; i < 3; i++) begin
                e_rdy  = m_inx[i] && (m_acc[i] == ws_of(i));
                e_done = e_rdy && psel[i] && PENABLE;
                e_err  = e_rdy && bad_access(PADDR, PWRITE);
                e_rd   = (e_done && !bad_access(PADDR, PWRITE)) ? m_reg(i, PADDR) : 32'h0;
                check($sformatf("PREADY[%0d]", i),   32'(pready[i]),  32'(e_rdy));
                check($sformatf("PSLVERR[%0d]", i),  32'(pslverr[i]), 32'(e_err));
                check($sformatf("PRDATA[%0d]", i),   prdata[i],       e_rd);
                check($sformatf("GPIO_OUT[%0d]", i), 32'(gout[i]),    32'(m_dout[i]));
                check($sformatf("GPIO_OE[%0d]", i),  32'(goe[i]),     32'(m_dir[i]));
                check($sformatf("INT[%0d]", i),      32'(int_o[i]),   32'(|(m_istat[i] & m_ien[i])));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic apb(input int i, input bit w, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output bit err, output int cyc);
        @(posedge HCLK); #3;
        psel = '0; psel[i] = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        cyc = 1; rd = '0; err = 1'b0;
        @(posedge HCLK); #3;
        PENABLE = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc++;
            @(negedge HCLK);
            if (pready[i]) begin
                rd  = prdata[i];
                err = pslverr[i];
                return;
            end
            @(posedge HCLK); #3;
        end
        check("apb_pready_timeout", 32'(cyc), 32'(ws_of(i) + 2));
    endtask

    task automatic bus_idle();
        @(posedge HCLK); #3;
        psel = '0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        bit          er;
        int          cy;
        HRESETN = 1'b0; psel = '0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        gpio_in = 8'h40;                       // held high through reset
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("reset_PRDATA",   prdata[0],          32'h0);
        check("reset_PREADY",   32'(pready[0]),     32'h0);
        check("reset_PSLVERR",  32'(pslverr[0]),    32'h0);
        check("reset_GPIO_OUT", 32'(gout[0]),       32'h0);
        check("reset_GPIO_OE",  32'(goe[0]),        32'h0);
        check("reset_INT",      32'(int_o[0]),      32'h0);
        @(posedge HCLK); #3 HRESETN = 1'b1;
        repeat (6) @(posedge HCLK);

        // 1: write/read DOUT with one wait state
        apb(0, 1'b1, 8'h00, 32'h0000_00A5, rd, er, cy);
        check("t1_wr_cycles", 32'(cy), 32'd3);
        check("t1_wr_err", 32'(er), 32'd0);
        bus_idle();
        @(negedge HCLK);
        check("t1_GPIO_OUT", 32'(gout[0]), 32'hA5);
        apb(0, 1'b0, 8'h00, 32'h0, rd, er, cy);
        check("t1_rd_data", rd, 32'h0000_00A5);
        check("t1_rd_err", 32'(er), 32'd0);
        bus_idle();

        // pin high through reset: DIN shows it, ISTAT stays clear
        apb(0, 1'b0, 8'h08, 32'h0, rd, er, cy);
        check("rst_pin_DIN", rd, 32'h0000_0040);
        apb(0, 1'b0, 8'h10, 32'h0, rd, er, cy);
        check("rst_pin_ISTAT", rd, 32'h0);
        bus_idle();

        // 2: back-to-back zero-wait writes, IEN masked to WIDTH
        apb(1, 1'b1, 8'h04, 32'h0000_000F, rd, er, cy);
        check("t2_wr1_cycles", 32'(cy), 32'd2);
        apb(1, 1'b1, 8'h0C, 32'hFFFF_FFFF, rd, er, cy);
        check("t2_wr2_cycles", 32'(cy), 32'd2);
        bus_idle();
        @(negedge HCLK);
        check("t2_GPIO_OE", 32'(goe[1]), 32'h0F);
        apb(1, 1'b0, 8'h0C, 32'h0, rd, er, cy);
        check("t2_rd_IEN", rd, 32'h0000_00FF);
        bus_idle();

        // 3: error responses
        apb(0, 1'b1, 8'h08, 32'h0000_00FF, rd, er, cy);
        check("t3_wr_din_err", 32'(er), 32'd1);
        apb(0, 1'b0, 8'h14, 32'h0, rd, er, cy);
        check("t3_rd_14_err", 32'(er), 32'd1);
        check("t3_rd_14_data", rd, 32'h0);
        apb(0, 1'b0, 8'h02, 32'h0, rd, er, cy);
        check("t3_misaligned_err", 32'(er), 32'd1);
        apb(0, 1'b0, 8'h08, 32'h0, rd, er, cy);
        check("t3_DIN_kept", rd, 32'h0000_0040);
        check("t3_DIN_err", 32'(er), 32'd0);
        bus_idle();

        // 4: rising edge on bit 3 with IEN=0x08, then W1C
        apb(0, 1'b1, 8'h0C, 32'h0000_0008, rd, er, cy);
        bus_idle();
        @(posedge HCLK); #3 gpio_in = 8'h48;
        @(posedge HCLK);                       // sampling edge
        @(posedge HCLK);
        @(negedge HCLK);
        check("t4_INT_early", 32'(int_o[0]), 32'd0);
        @(posedge HCLK);
        @(negedge HCLK);
        check("t4_INT_set", 32'(int_o[0]), 32'd1);
        apb(0, 1'b0, 8'h10, 32'h0, rd, er, cy);
        check("t4_ISTAT", rd, 32'h0000_0008);
        apb(0, 1'b0, 8'h08, 32'h0, rd, er, cy);
        check("t4_DIN", rd, 32'h0000_0048);
        apb(0, 1'b1, 8'h10, 32'h0000_0008, rd, er, cy);
        bus_idle();
        @(negedge HCLK);
        check("t4_INT_clr", 32'(int_o[0]), 32'd0);
        apb(0, 1'b0, 8'h10, 32'h0, rd, er, cy);
        check("t4_ISTAT_clr", rd, 32'h0);
        bus_idle();

        // 5: edge on bit 2 lands on the same edge as a W1C of bit 2
        fork
            apb(0, 1'b1, 8'h10, 32'h0000_0004, rd, er, cy);
            begin
                @(posedge HCLK); #3 gpio_in = 8'h4C;
            end
        join
        bus_idle();
        apb(0, 1'b0, 8'h10, 32'h0, rd, er, cy);
        check("t5_set_wins", rd, 32'h0000_0004);
        bus_idle();

        // 6: reset in the middle of a three-wait-state write
        apb(2, 1'b1, 8'h00, 32'h0000_0011, rd, er, cy);
        check("t6_pre_cycles", 32'(cy), 32'd5);
        bus_idle();
        @(negedge HCLK);
        check("t6_pre_GPIO_OUT", 32'(gout[2]), 32'h11);
        @(posedge HCLK); #3;
        psel = 3'b100; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h0000_003C;
        @(posedge HCLK); #3 PENABLE = 1'b1;
        @(posedge HCLK); #3 HRESETN = 1'b0;
        #1;
        check("t6_rst_GPIO_OUT", 32'(gout[2]), 32'h0);
        check("t6_rst_PREADY", 32'(pready[2]), 32'h0);
        repeat (2) @(posedge HCLK);
        #3 HRESETN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            check("t6_idle_PREADY", 32'(pready[2]), 32'h0);
        end
        bus_idle();
        @(negedge HCLK);
        check("t6_post_GPIO_OUT", 32'(gout[2]), 32'h0);
        apb(2, 1'b0, 8'h00, 32'h0, rd, er, cy);
        check("t6_post_rd", rd, 32'h0);
        check("t6_post_cycles", 32'(cy), 32'd5);
        apb(2, 1'b0, 8'h10, 32'h0, rd, er, cy);
        check("t6_post_ISTAT", rd, 32'h0);
        bus_idle();
        repeat (3) @(posedge HCLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
